game_event_fifo: RTL and testbench

GAME_EVENT_FIFO -- requirements
Module: game_event_fifo

---
 rtl/game_event_fifo_if.sv | 33 +++
 rtl/game_event_fifo.sv | 155 +++++++++++++++
 tb/tb_game_event_fifo.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_event_fifo_if.sv
// Event-FIFO port bundle: upstream counter flags and record capture fields,
// plus the consumer handshake and status outputs.
interface game_event_fifo_if #(
  parameter int unsigned COUNT_WIDTH = 5,
  parameter int unsigned DEPTH       = 4
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic                   winner;
  logic                   loser;
  logic                   gameover;
  logic [1:0]             who;
  logic [COUNT_WIDTH-1:0] count;
  logic                   clear;
  logic                   out_ready;
  logic                   out_valid;
  logic [COUNT_WIDTH+3:0] out_rec;
  logic [LW-1:0]          level;
  logic                   overflow;
  logic                   over;

  // Producer/consumer side
  modport master (
    output winner, loser, gameover, who, count, clear, out_ready,
    input  out_valid, out_rec, level, overflow, over
  );

  // FIFO side
  modport slave (
    input  winner, loser, gameover, who, count, clear, out_ready,
    output out_valid, out_rec, level, overflow, over
  );
endinterface

// File: rtl/game_event_fifo.sv
// Game event FIFO: turns rising edges of winner/loser/gameover into
// {type, who, count} records, queues them, and freezes after GAMEOVER
// until cleared. DEPTH must be a power of two and at least 2.
module game_event_fifo #(
  parameter int unsigned COUNT_WIDTH = 5,
  parameter int unsigned DEPTH       = 4
) (
  input  logic             clk,
  input  logic             rst,
  game_event_fifo_if.slave bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned RW = COUNT_WIDTH + 4;

  localparam logic [1:0] TYPE_WIN  = 2'b00;
  localparam logic [1:0] TYPE_LOSE = 2'b01;
  localparam logic [1:0] TYPE_GO   = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_OVER = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          win_q, win_d;
  logic          lose_q, lose_d;
  logic          go_q, go_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [RW-1:0] mem_q [DEPTH];
  logic [RW-1:0] mem_d [DEPTH];
  logic [RW-1:0] out_rec_q, out_rec_d;
  logic          out_valid_q, out_valid_d;
  logic          overflow_q, overflow_d;
  logic          over_q, over_d;

  logic          win_edge, lose_edge, go_edge;
  logic          ev_en;
  logic          push_req, lower_drop;
  logic          full, pop, push;
  logic [RW-1:0] push_rec, head_rec;

  // Rising-edge detection; events only count while running and not clearing
  always_comb begin
    win_d     = bus.winner;
    lose_d    = bus.loser;
    go_d      = bus.gameover;
    win_edge  = bus.winner   & ~win_q;
    lose_edge = bus.loser    & ~lose_q;
    go_edge   = bus.gameover & ~go_q;
    ev_en     = (state_q == ST_RUN) & ~bus.clear;
  end

  // Priority select of the single record to push, and RUN/OVER next state
  always_comb begin
    push_req   = 1'b0;
    push_rec   = '0;
    lower_drop = 1'b0;
    state_d    = state_q;
    if (ev_en) begin
      if (go_edge) begin
        push_req   = 1'b1;
        push_rec   = {TYPE_GO, bus.who, bus.count};
        lower_drop = win_edge | lose_edge;
        state_d    = ST_OVER;
      end else if (win_edge) begin
        push_req   = 1'b1;
        push_rec   = {TYPE_WIN, bus.who, bus.count};
        lower_drop = lose_edge;
      end else if (lose_edge) begin
        push_req   = 1'b1;
        push_rec   = {TYPE_LOSE, bus.who, bus.count};
      end
    end
    if (bus.clear) begin
      state_d = ST_RUN;
    end
  end

  // Storage, pointers, level, overflow and the registered head record
  always_comb begin
    full        = (level_q == LW'(DEPTH));
    pop         = out_valid_q & bus.out_ready & ~bus.clear;
    push        = push_req & (~full | pop);
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    overflow_d  = overflow_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_rec;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    level_d = level_q + LW'(push) - LW'(pop);
    if (lower_drop || (push_req && !push)) begin
      overflow_d = 1'b1;
    end
    if (bus.clear) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end
    // A record written this cycle into the slot that becomes head bypasses the array
    head_rec    = (push && (wr_ptr_q == rd_ptr_d)) ? push_rec : mem_q[rd_ptr_d];
    out_valid_d = (level_d != '0);
    out_rec_d   = out_valid_d ? head_rec : '0;
    over_d      = (state_d == ST_OVER);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      go_q        <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      out_rec_q   <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      over_q      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      go_q        <= go_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      out_rec_q   <= out_rec_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      over_q      <= over_d;
      mem_q       <= mem_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_rec   = out_rec_q;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.over      = over_q;

endmodule

// File: tb/tb_game_event_fifo.sv
// Scoreboard bench for game_event_fifo: directed pulses push expected records,
// a negedge monitor pops and compares every record the consumer accepts.
module tb_game_event_fifo;

  localparam int unsigned CW    = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RW    = CW + 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  game_event_fifo_if #(.COUNT_WIDTH(CW), .DEPTH(DEPTH)) bus ();

  game_event_fifo #(.COUNT_WIDTH(CW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int            n_tests   = 0;
  int            n_fail    = 0;
  int            valid_cnt = 0;
  logic [RW-1:0] exp_q [$];
  logic [RW-1:0] exp_rec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input logic [1:0] t, input logic [1:0] w, input logic [CW-1:0] c);
    return {t, w, c};
  endfunction

  // Monitor: every accepted record must match the scoreboard head
  always @(negedge clk) begin
    if (bus.out_valid) valid_cnt++;
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no record", bus.out_rec);
      end else begin
        exp_rec = exp_q.pop_front();
        check("pop_rec", 32'(bus.out_rec), 32'(exp_rec));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic w, input logic l, input logic g,
                       input logic [1:0] who, input logic [CW-1:0] cnt);
    bus.winner   = w;
    bus.loser    = l;
    bus.gameover = g;
    bus.who      = who;
    bus.count    = cnt;
    step();
    bus.winner   = 1'b0;
    bus.loser    = 1'b0;
    bus.gameover = 1'b0;
    step();
  endtask

  task automatic drain(input string name);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.level == 0) break;
      step();
    end
    @(negedge clk);
    check({name, "_level"}, 32'(bus.level), 32'd0);
    check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  task automatic do_clear(input string name);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check({name, "_level"},    32'(bus.level),     32'd0);
    check({name, "_overflow"}, 32'(bus.overflow),  32'd0);
    check({name, "_over"},     32'(bus.over),      32'd0);
    check({name, "_valid"},    32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.winner    = 1'b0;
    bus.loser     = 1'b0;
    bus.gameover  = 1'b0;
    bus.who       = 2'd0;
    bus.count     = '0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid",    32'(bus.out_valid), 32'd0);
    check("rst_rec",      32'(bus.out_rec),   32'd0);
    check("rst_level",    32'(bus.level),     32'd0);
    check("rst_overflow", 32'(bus.overflow),  32'd0);
    check("rst_over",     32'(bus.over),      32'd0);
    rst = 1'b1;
    step();

    // Single WIN record with immediate consumption
    bus.out_ready = 1'b1;
    valid_cnt = 0;
    exp_q.push_back(9'b00_10_11111);
    pulse(1'b1, 1'b0, 1'b0, 2'd2, 5'd31);
    step();
    @(negedge clk);
    check("t1_valid_cycles", 32'(valid_cnt), 32'd1);
    check("t1_level", 32'(bus.level), 32'd0);
    bus.out_ready = 1'b0;

    // Five pushes into a four-deep FIFO with no consumer
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(mk(2'b00, 2'd1, CW'(i)));
      pulse(1'b1, 1'b0, 1'b0, 2'd1, CW'(i));
    end
    @(negedge clk);
    check("t2_level",    32'(bus.level),    32'd4);
    check("t2_overflow", 32'(bus.overflow), 32'd1);
    check("t2_head_held", 32'(bus.out_rec), 32'(9'b00_01_00001));
    drain("t2_drain");
    do_clear("t2_clear");

    // Simultaneous winner and loser edges: WIN wins, LOSE is dropped
    exp_q.push_back(9'b00_11_00111);
    pulse(1'b1, 1'b1, 1'b0, 2'd3, 5'd7);
    @(negedge clk);
    check("t3_level",    32'(bus.level),    32'd1);
    check("t3_overflow", 32'(bus.overflow), 32'd1);
    drain("t3_drain");
    do_clear("t3_clear");

    // Lone LOSE record
    exp_q.push_back(9'b01_01_01001);
    pulse(1'b0, 1'b1, 1'b0, 2'd1, 5'd9);
    drain("t3b_drain");

    // GAMEOVER freezes the FIFO until clear
    exp_q.push_back(9'b10_10_00000);
    pulse(1'b0, 1'b0, 1'b1, 2'd2, 5'd0);
    @(negedge clk);
    check("t4_over",  32'(bus.over),  32'd1);
    check("t4_level", 32'(bus.level), 32'd1);
    pulse(1'b1, 1'b0, 1'b0, 2'd1, 5'd4);
    pulse(1'b1, 1'b1, 1'b0, 2'd1, 5'd5);
    @(negedge clk);
    check("t4_level_frozen", 32'(bus.level),    32'd1);
    check("t4_overflow",     32'(bus.overflow), 32'd0);
    check("t4_rec",          32'(bus.out_rec),  32'(9'b10_10_00000));
    do_clear("t4_clear");

    // Full FIFO with simultaneous push and pop
    for (int i = 10; i <= 13; i++) begin
      exp_q.push_back(mk(2'b00, 2'd0, CW'(i)));
      pulse(1'b1, 1'b0, 1'b0, 2'd0, CW'(i));
    end
    @(negedge clk);
    check("t5_full_level", 32'(bus.level), 32'd4);
    step();
    exp_q.push_back(9'b00_00_01110);
    bus.winner    = 1'b1;
    bus.who       = 2'd0;
    bus.count     = 5'd14;
    bus.out_ready = 1'b1;
    step();
    bus.winner    = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("t5_level",    32'(bus.level),    32'd4);
    check("t5_overflow", 32'(bus.overflow), 32'd0);
    drain("t5_drain");

    // Asynchronous reset between edges with three records stored
    for (int i = 20; i <= 22; i++) begin
      exp_q.push_back(mk(2'b00, 2'd3, CW'(i)));
      pulse(1'b1, 1'b0, 1'b0, 2'd3, CW'(i));
    end
    @(negedge clk);
    check("t6_level_pre", 32'(bus.level), 32'd3);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("t6_level_async", 32'(bus.level),     32'd0);
    check("t6_valid_async", 32'(bus.out_valid), 32'd0);
    exp_q.delete();

    // Input already high at reset release counts as an edge
    bus.winner = 1'b1;
    bus.who    = 2'd0;
    bus.count  = 5'd3;
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(9'b00_00_00011);
    step();
    check("t6_release_level", 32'(bus.level), 32'd1);
    drain("t6_drain");
    bus.winner = 1'b0;
    step();

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
